data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Word-organised data RAM that acts as the responder end of the core's data-memory ready/valid interface. It accepts one load or store per transaction from the core's data-memory initiator and applies byte enables on stores. Each transaction is acknowledged with a one-cycle ready pulse, then a one-cycle response pulse after a programmable wait latency. It sits beside the core in the top-level SoC, and its ports connect one-to-one to the core's cpu_mem_* ports.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; must be a power of 2.
LATENCY, 1, wait cycles between the ready pulse and the response pulse; legal range 0..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
mem_valid_in  in  1  request valid; held by the initiator until it sees a response
mem_read_en_in  in  1  load request
mem_write_en_in  in  1  store request
mem_addr_in  in  32  byte address
mem_wdata_in  in  32  store data
mem_byte_en_in  in  4  store byte enables; bit i enables wdata[8i+7:8i]
mem_ready_out  out  1  one-cycle request-accepted pulse
mem_valid_out  out  1  one-cycle response pulse
mem_rdata_out  out  32  load data; registered
mem_err_out  out  1  pulses together with mem_valid_out when the address is out of range
busy_out  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - mem_ready_out, mem_valid_out, mem_err_out and busy_out go to 0.
  - mem_rdata_out goes to 32'h0.
  - State goes to IDLE and the wait counter to 0.
  - RAM contents are not cleared.
  - A reset taken mid-transaction drops that transaction. An uncommitted store never writes the RAM.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE: on an edge where mem_valid_in=1:
  - latch addr, wdata, byte_en, read_en and write_en;
  - set mem_ready_out<=1 for exactly one cycle;
  - load the wait counter with LATENCY;
  - go to WAIT.
  Request inputs are ignored in every other state.
- WAIT: if the counter is nonzero, decrement it. If it is 0, perform the access, set mem_valid_out<=1 and go to RESP.
  - Result: with LATENCY=L, mem_valid_out rises L+1 cycles after mem_ready_out rises.
- Address decode:
  - offset = latched_addr - BASE_ADDR (32-bit, wraps on underflow).
  - in_range = (offset >> 2) < DEPTH_WORDS.
  - Word index = offset[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored; there is no misalignment fault.
- Access at the WAIT exit edge:
  - write_en=1 and in range: for each byte lane i with byte_en[i]=1, write wdata byte i. Other lanes are unchanged. byte_en=0 is a legal no-op. mem_rdata_out<=0.
  - read_en=1 only, in range: mem_rdata_out<=RAM[index], the pre-edge contents.
  - Both read_en and write_en set: treated as a store; mem_rdata_out<=0.
  - Neither set: no access; mem_rdata_out<=0; a normal response is still given.
  - Out of range: no RAM write; mem_rdata_out<=0; mem_err_out<=1 for the response cycle.
- mem_rdata_out holds its value until the next response edge.
- RESP: clear mem_valid_out and mem_err_out. If mem_valid_in=1 go to DRAIN, else go to IDLE.
- DRAIN: stay until mem_valid_in=0, then go to IDLE. This prevents re-accepting a request the initiator has not yet dropped.
- Throughput: at most one transaction per LATENCY+3 cycles. No pipelining, no queuing.
- mem_ready_out and mem_valid_out are never high in the same cycle.

Test Plan:
- Reset then idle: after rst=0 for 2 cycles, all outputs are 0. With mem_valid_in=0 for 10 cycles, ready and valid stay 0.
- Store then load, LATENCY=1:
  - store addr 0x10, wdata 0xDEADBEEF, byte_en 4'hF: ready pulses 1 cycle, valid pulses 2 cycles later, err=0.
  - load addr 0x10: mem_rdata_out=0xDEADBEEF on the valid cycle.
- Byte enables: word 0x20 holds 0x11223344. Store wdata 0xAABBCCDD with byte_en 4'b0101. A load of 0x20 returns 0x11BB33DD.
- Out of range, DEPTH_WORDS=16: store to 0x40 gives err=1 on the response. A load of 0x40 returns 0 with err=1. Word 0 is unchanged.
- Latency and hold-off, LATENCY=3: valid rises 4 cycles after ready. If mem_valid_in stays high for 3 cycles after the response, the block stays in DRAIN with no second ready pulse. Ready occurs again only after valid_in falls and rises again.
- Reset mid-transaction: assert rst=0 during WAIT of a store to 0x30 with wdata 0x55555555. Nothing is written; a subsequent load of 0x30 returns the old value 0x00000000.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM acting as the responder end of the core's
// data-memory ready/valid interface. One load or store per transaction:
// a one-cycle ready pulse on accept, then a one-cycle response pulse
// LATENCY+1 cycles later. Stores honour per-byte enables.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  input  logic [3:0]  mem_byte_en_in,
  output logic        mem_ready_out,
  output logic        mem_valid_out,
  output logic [31:0] mem_rdata_out,
  output logic        mem_err_out,
  output logic        busy_out
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]  wait_cnt;

  // Latched request
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_rd;
  logic        req_wr;

  // Address decode
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;

  // Control strobes from the output decode
  logic accept;
  logic access;
  logic ram_we;

  logic [31:0] ram [DEPTH_WORDS];

  // Byte offset from the base wraps on underflow, so addresses below
  // BASE_ADDR land far above the top and read as out of range.
  // Comparing the full byte offset against 4*DEPTH_WORDS is equivalent to
  // comparing the word offset against DEPTH_WORDS.
  always_comb begin
    offset   = req_addr - BASE_ADDR;
    in_range = ({2'b00, offset} < (34'(DEPTH_WORDS) * 34'd4));
    word_idx = offset[IDX_W+1:2];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (mem_valid_in) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_valid_in) begin
          state_next = DRAIN;
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (!mem_valid_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: accept/access strobes and busy flag
  always_comb begin
    accept   = (state == IDLE) && mem_valid_in;
    access   = (state == WAIT) && (wait_cnt == 4'd0);
    // A reset arriving on the access edge must not commit the store.
    ram_we   = access && req_wr && in_range && rst;
    busy_out = (state != IDLE);
  end

  // Capture the request on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr  <= mem_addr_in;
      req_wdata <= mem_wdata_in;
      req_be    <= mem_byte_en_in;
      req_rd    <= mem_read_en_in;
      req_wr    <= mem_write_en_in;
    end
  end

  // Wait counter and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_ready_out <= 1'b0;
      mem_valid_out <= 1'b0;
      mem_err_out   <= 1'b0;
      mem_rdata_out <= '0;
      wait_cnt      <= '0;
    end else begin
      mem_ready_out <= accept;

      if (accept) begin
        wait_cnt <= 4'(LATENCY);
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (access) begin
        mem_valid_out <= 1'b1;
        mem_err_out   <= !in_range;
        if (req_rd && !req_wr && in_range) begin
          mem_rdata_out <= ram[word_idx];
        end else begin
          mem_rdata_out <= '0;
        end
      end else begin
        mem_valid_out <= 1'b0;
        mem_err_out   <= 1'b0;
      end
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          ram[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
